sargantana_icache_ifill_buffer: RTL and testbench
=================================================

// Module: sargantana_icache_ifill_buffer
// PURPOSE
// Refill stage between the icache miss logic and the L2/memory port. Takes one line-miss
// address, issues a line request, assembles the returned beats into a full cache line, and
// presents that line on fill_data_o. fill_data_o feeds the tag/data array write and the
// checker's ifill_data_i. Exactly one miss is outstanding at a time; flush aborts it.
// PARAMETERS
// PADDR_WIDTH  40   physical address width
// LINE_WIDTH   512  cache line width in bits (= icache way width)
// BEAT_WIDTH   128  L2 response data width; LINE_WIDTH % BEAT_WIDTH == 0
// PORTS
// clk_i          in   1            clock
// rst_i          in   1            synchronous reset, active-high
// flush_i        in   1            abort outstanding miss (fence.i / pipeline kill)
// miss_valid_i   in   1            miss request from the icache control
// miss_paddr_i   in   PADDR_WIDTH  missing physical address (any byte offset)
// miss_ready_o   out  1            miss accepted when valid&ready
// req_valid_o    out  1            line request to L2
// req_paddr_o    out  PADDR_WIDTH  line-aligned address (low log2(LINE_WIDTH/8) bits = 0)
// req_ready_i    in   1            L2 accepts request
// rsp_valid_i    in   1            one response beat valid (no backpressure; always consumed)
// rsp_data_i     in   BEAT_WIDTH   beat data, in ascending address order
// rsp_error_i    in   1            bus error on this beat
// fill_valid_o   out  1            assembled line available
// fill_data_o    out  LINE_WIDTH   assembled line, beat k in [k*BEAT_WIDTH +: BEAT_WIDTH]
// fill_paddr_o   out  PADDR_WIDTH  line-aligned address of the fill
// fill_error_o   out  1            at least one beat carried rsp_error_i
// fill_ready_i   in   1            array write / consumer takes the line
// BEHAVIOUR
// - NBEATS = LINE_WIDTH/BEAT_WIDTH. beat_cnt is $clog2(NBEATS) bits. Registers: addr, line
//   buffer, beat_cnt, err (sticky), state.
// - Reset (rst_i=1 at posedge): state=IDLE, beat_cnt=0, err=0. Outputs then: miss_ready_o=1,
//   req_valid_o=0, fill_valid_o=0, fill_error_o=0, req_paddr_o/fill_paddr_o=0, fill_data_o=0.
//   Reset overrides every state, including mid-fill; in-flight beats after reset are ignored.
// - IDLE: miss_ready_o = ~flush_i. On miss_valid_i & miss_ready_o: latch the aligned address,
//   clear beat_cnt and err, go to REQ. flush_i together with miss_valid_i: flush wins and the
//   miss is not accepted.
// - REQ: req_valid_o=1 with a stable req_paddr_o until req_ready_i; never withdrawn. On the
//   handshake go to RESP, or to DRAIN if flush_i is seen in this cycle or was seen earlier in
//   REQ (flush_pend flag).
// - RESP: each rsp_valid_i writes the beat into slot beat_cnt and ORs rsp_error_i into err.
//   beat_cnt increments, wrapping to 0 after NBEATS-1. On the last beat go to FILL the next
//   cycle. Beats can arrive back-to-back or gapped. flush_i -> DRAIN; the beat in the same
//   cycle is counted.
// - FILL: fill_valid_o=1; data, paddr and error are stable until fill_ready_i. Handshake ->
//   IDLE. Minimum miss-to-fill latency: 1 (REQ) + NBEATS beats + 1 cycle. flush_i in FILL ->
//   IDLE, fill_valid_o deasserts next cycle, and the line is discarded if not yet accepted.
//   flush_i with fill_ready_i in the same cycle: the handshake completes and the line counts
//   as accepted.
// - DRAIN: outputs idle, miss_ready_o=0. Consumes the remaining beats of the aborted line
//   (beat_cnt counts on), then IDLE. fill_valid_o is never raised.
// - rsp_valid_i in IDLE/REQ/FILL is a protocol violation (SVA assert) and is ignored.
// - fill_error_o=1: consumer writes data but must not set the way valid bit.
// STRUCTURE
// - sargantana_icache_pkg gains: ifill_state_t enum {IFILL_IDLE, IFILL_REQ, IFILL_RESP,
//   IFILL_FILL, IFILL_DRAIN}; localparam ICACHE_LINE_BEATS; typedef ifill_req_t
//   {valid, paddr}.
// - No sub-module; the FSM, beat counter and line buffer stay in one always_ff/always_comb pair.
// - SVA: req_paddr_o stable while req_valid_o&~req_ready_i; fill_* stable while
//   fill_valid_o&~fill_ready_i.
// TESTING
// 1 miss 0x80001234, req_ready_i same cycle, 4 back-to-back beats A0..A3 -> req_paddr_o
//   0x80001200; fill_valid_o 1 cycle after A3; fill_data_o={A3,A2,A1,A0}; fill_error_o=0.
// 2 req_ready_i held low 5 cycles, beats gapped by 2 idle cycles, fill_ready_i low 3 cycles
//   -> request, data and address stable throughout; single fill handshake; back to IDLE.
// 3 flush_i in RESP after beat 1 -> DRAIN swallows beats 2,3; no fill_valid_o; a new miss
//   0x1040 is accepted afterwards and fills with its own data only.
// 4 flush_i in REQ before req_ready_i -> req_valid_o held until accepted, then DRAIN 4 beats,
//   no fill.
// 5 rsp_error_i on beat 2 only -> fill_error_o=1 on fill; next miss has fill_error_o=0.
// 6 rst_i asserted in RESP after beat 2 -> next cycle all outputs at reset values; a stray
//   late beat is ignored; a fresh miss completes normally.

Source files
------------

// File: rtl/sargantana_icache_pkg.sv
// Shared icache types and sizing: refill FSM states, line geometry, and the L2 line-request bundle.
package sargantana_icache_pkg;

  localparam int ICACHE_PADDR_WIDTH = 40;
  localparam int ICACHE_LINE_WIDTH  = 512;
  localparam int ICACHE_BEAT_WIDTH  = 128;
  localparam int ICACHE_LINE_BEATS  = ICACHE_LINE_WIDTH / ICACHE_BEAT_WIDTH;

  typedef enum logic [2:0] {
    IFILL_IDLE  = 3'd0,
    IFILL_REQ   = 3'd1,
    IFILL_RESP  = 3'd2,
    IFILL_FILL  = 3'd3,
    IFILL_DRAIN = 3'd4
  } ifill_state_t;

  typedef struct packed {
    logic                          valid;
    logic [ICACHE_PADDR_WIDTH-1:0] paddr;
  } ifill_req_t;

endpackage

// File: rtl/sargantana_icache_ifill_buffer.sv
// Icache refill buffer: one outstanding line miss, beats assembled into a full line,
// flush aborts the miss and drains whatever beats the L2 still owes.
module sargantana_icache_ifill_buffer
  import sargantana_icache_pkg::*;
#(
  parameter int PADDR_WIDTH = ICACHE_PADDR_WIDTH,
  parameter int LINE_WIDTH  = ICACHE_LINE_WIDTH,
  parameter int BEAT_WIDTH  = ICACHE_BEAT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   miss_valid_i,
  input  logic [PADDR_WIDTH-1:0] miss_paddr_i,
  output logic                   miss_ready_o,
  output logic                   req_valid_o,
  output logic [PADDR_WIDTH-1:0] req_paddr_o,
  input  logic                   req_ready_i,
  input  logic                   rsp_valid_i,
  input  logic [BEAT_WIDTH-1:0]  rsp_data_i,
  input  logic                   rsp_error_i,
  output logic                   fill_valid_o,
  output logic [LINE_WIDTH-1:0]  fill_data_o,
  output logic [PADDR_WIDTH-1:0] fill_paddr_o,
  output logic                   fill_error_o,
  input  logic                   fill_ready_i
);

  localparam int NBEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0]       LAST_BEAT   = CNT_W'(NBEATS - 1);
  localparam logic [PADDR_WIDTH-1:0] OFFSET_MASK = PADDR_WIDTH'(LINE_WIDTH / 8 - 1);

  ifill_state_t                         state;
  logic [CNT_W-1:0]                     beat_cnt;
  logic                                 err;
  logic                                 flush_pend;
  logic                                 rst_q;
  logic [PADDR_WIDTH-1:0]               addr;
  logic [NBEATS-1:0][BEAT_WIDTH-1:0]    line;
  logic                                 last_beat;

  function automatic logic [CNT_W-1:0] next_beat(input logic [CNT_W-1:0] cnt);
    return (cnt == LAST_BEAT) ? '0 : cnt + CNT_W'(1);
  endfunction

  assign last_beat = rsp_valid_i && (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk_i) begin
    rst_q <= rst_i;
    // Address and line storage carry no reset; outputs are gated by state instead.
    if (state == IFILL_IDLE && miss_valid_i && !flush_i) addr <= miss_paddr_i & ~OFFSET_MASK;
    if (state == IFILL_RESP && rsp_valid_i) line[beat_cnt] <= rsp_data_i;

    if (rst_i) begin
      state      <= IFILL_IDLE;
      beat_cnt   <= '0;
      err        <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      unique case (state)
        IFILL_IDLE: begin
          if (miss_valid_i && !flush_i) begin
            state      <= IFILL_REQ;
            beat_cnt   <= '0;
            err        <= 1'b0;
            flush_pend <= 1'b0;
          end
        end
        IFILL_REQ: begin
          // The request cannot be withdrawn, so a flush is remembered until the L2 takes it.
          if (req_ready_i) state <= (flush_i || flush_pend) ? IFILL_DRAIN : IFILL_RESP;
          else if (flush_i) flush_pend <= 1'b1;
        end
        IFILL_RESP: begin
          if (rsp_valid_i) begin
            beat_cnt <= next_beat(beat_cnt);
            err      <= err | rsp_error_i;
          end
          if (flush_i) state <= last_beat ? IFILL_IDLE : IFILL_DRAIN;
          else if (last_beat) state <= IFILL_FILL;
        end
        IFILL_FILL: begin
          if (fill_ready_i || flush_i) state <= IFILL_IDLE;
        end
        IFILL_DRAIN: begin
          if (rsp_valid_i) begin
            beat_cnt <= next_beat(beat_cnt);
            if (beat_cnt == LAST_BEAT) state <= IFILL_IDLE;
          end
        end
        default: state <= IFILL_IDLE;
      endcase
    end
  end

  always_comb begin
    miss_ready_o = (state == IFILL_IDLE) && !flush_i;
    req_valid_o  = (state == IFILL_REQ);
    req_paddr_o  = req_valid_o ? addr : '0;
    fill_valid_o = (state == IFILL_FILL);
    fill_paddr_o = fill_valid_o ? addr : '0;
    fill_data_o  = fill_valid_o ? line : '0;
    fill_error_o = fill_valid_o && err;
  end

  a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    req_valid_o && !req_ready_i |=> $stable(req_paddr_o));

  a_fill_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    fill_valid_o && !fill_ready_i && !flush_i |=>
      fill_valid_o && $stable(fill_data_o) && $stable(fill_paddr_o) && $stable(fill_error_o));

  // Beats of a request killed by reset may still trickle in the cycle after it.
  a_rsp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_valid_i && !rst_q |-> (state == IFILL_RESP || state == IFILL_DRAIN));

endmodule

// File: tb/tb_sargantana_icache_ifill_buffer.sv
// Directed bench for the icache refill buffer: one task per scenario, inline checks.
module tb_sargantana_icache_ifill_buffer;

  localparam int PW = 40;
  localparam int LW = 512;
  localparam int BW = 128;

  logic          clk_i = 1'b0;
  logic          rst_i, flush_i, miss_valid_i, req_ready_i, rsp_valid_i, rsp_error_i, fill_ready_i;
  logic [PW-1:0] miss_paddr_i, req_paddr_o, fill_paddr_o;
  logic [BW-1:0] rsp_data_i;
  logic [LW-1:0] fill_data_o;
  logic          miss_ready_o, req_valid_o, fill_valid_o, fill_error_o;

  int n_checks = 0;
  int n_pass   = 0;
  int fill_hs  = 0;
  int fill_cyc = 0;

  always #5 clk_i = ~clk_i;

  sargantana_icache_ifill_buffer dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .miss_valid_i(miss_valid_i), .miss_paddr_i(miss_paddr_i), .miss_ready_o(miss_ready_o),
    .req_valid_o(req_valid_o), .req_paddr_o(req_paddr_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .rsp_error_i(rsp_error_i),
    .fill_valid_o(fill_valid_o), .fill_data_o(fill_data_o), .fill_paddr_o(fill_paddr_o),
    .fill_error_o(fill_error_o), .fill_ready_i(fill_ready_i)
  );

  always @(posedge clk_i) begin
    if (fill_valid_o && fill_ready_i) fill_hs++;
    if (fill_valid_o) fill_cyc++;
  end

  function automatic logic [BW-1:0] mk(input logic [7:0] tag, input int k);
    return {tag, 8'(k), 16'h5A5A, 32'hC0DE_0000 + 32'(k), tag, 24'(k * 3 + 1), 8'(k), tag, 16'hF00D};
  endfunction

  function automatic logic [LW-1:0] mk_line(input logic [7:0] tag);
    return {mk(tag, 3), mk(tag, 2), mk(tag, 1), mk(tag, 0)};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat(input logic [BW-1:0] d, input logic e);
    rsp_valid_i = 1'b1; rsp_data_i = d; rsp_error_i = e;
    tick();
    rsp_valid_i = 1'b0; rsp_data_i = '0; rsp_error_i = 1'b0;
  endtask

  task automatic start_miss(input logic [PW-1:0] a);
    miss_valid_i = 1'b1; miss_paddr_i = a;
    tick();
    miss_valid_i = 1'b0;
  endtask

  task automatic accept_req();
    req_ready_i = 1'b1;
    tick();
    req_ready_i = 1'b0;
  endtask

  task automatic take_fill();
    fill_ready_i = 1'b1;
    tick();
    fill_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; miss_valid_i = 1'b0; miss_paddr_i = '0; req_ready_i = 1'b0;
    rsp_valid_i = 1'b0; rsp_data_i = '0; rsp_error_i = 1'b0; fill_ready_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    n_checks++;
    if ({miss_ready_o, req_valid_o, fill_valid_o, fill_error_o} !== 4'b1000)
      $display("FAIL reset_ctrl: got %b exp 1000", {miss_ready_o, req_valid_o, fill_valid_o, fill_error_o});
    else n_pass++;
    n_checks++;
    if (req_paddr_o !== '0) $display("FAIL reset_req_paddr: got %h exp 0", req_paddr_o); else n_pass++;
    n_checks++;
    if (fill_paddr_o !== '0) $display("FAIL reset_fill_paddr: got %h exp 0", fill_paddr_o); else n_pass++;
    n_checks++;
    if (fill_data_o !== '0) $display("FAIL reset_fill_data: got %h exp 0", fill_data_o); else n_pass++;
  endtask

  task automatic test_basic();
    start_miss(40'h00_8000_1234);
    n_checks++;
    if ({req_valid_o, req_paddr_o} !== {1'b1, 40'h00_8000_1200})
      $display("FAIL basic_req: got %b %h exp 1 0080001200", req_valid_o, req_paddr_o);
    else n_pass++;
    n_checks++;
    if (miss_ready_o !== 1'b0) $display("FAIL basic_busy: got %b exp 0", miss_ready_o); else n_pass++;
    accept_req();
    for (int k = 0; k < 3; k++) beat(mk(8'hA0, k), 1'b0);
    n_checks++;
    if (fill_valid_o !== 1'b0) $display("FAIL basic_early_fill: got %b exp 0", fill_valid_o); else n_pass++;
    beat(mk(8'hA0, 3), 1'b0);
    n_checks++;
    if ({fill_valid_o, fill_error_o, fill_paddr_o} !== {2'b10, 40'h00_8000_1200})
      $display("FAIL basic_fill: got %b%b %h exp 10 0080001200", fill_valid_o, fill_error_o, fill_paddr_o);
    else n_pass++;
    n_checks++;
    if (fill_data_o !== mk_line(8'hA0))
      $display("FAIL basic_data: got %h exp %h", fill_data_o, mk_line(8'hA0));
    else n_pass++;
    take_fill();
    n_checks++;
    if ({fill_valid_o, miss_ready_o} !== 2'b01)
      $display("FAIL basic_idle: got %b exp 01", {fill_valid_o, miss_ready_o});
    else n_pass++;
  endtask

  task automatic test_stall();
    int hs0;
    logic ok;
    hs0 = fill_hs;
    start_miss(40'h12_3456_78E5);
    ok = 1'b1;
    repeat (5) begin
      if (!(req_valid_o === 1'b1 && req_paddr_o === 40'h12_3456_78C0)) ok = 1'b0;
      tick();
    end
    if (!(req_valid_o === 1'b1 && req_paddr_o === 40'h12_3456_78C0)) ok = 1'b0;
    accept_req();
    n_checks++;
    if (ok !== 1'b1) $display("FAIL stall_req_stable: got %b exp 1", ok); else n_pass++;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (2) begin
        if (fill_valid_o !== 1'b0) ok = 1'b0;
        tick();
      end
      if (fill_valid_o !== 1'b0) ok = 1'b0;
      beat(mk(8'h22, k), 1'b0);
    end
    n_checks++;
    if (ok !== 1'b1) $display("FAIL stall_no_early_fill: got %b exp 1", ok); else n_pass++;
    ok = 1'b1;
    repeat (3) begin
      if (!(fill_valid_o === 1'b1 && fill_data_o === mk_line(8'h22) &&
            fill_paddr_o === 40'h12_3456_78C0 && fill_error_o === 1'b0)) ok = 1'b0;
      tick();
    end
    if (!(fill_valid_o === 1'b1 && fill_data_o === mk_line(8'h22))) ok = 1'b0;
    n_checks++;
    if (ok !== 1'b1) $display("FAIL stall_fill_stable: got %b exp 1", ok); else n_pass++;
    take_fill();
    n_checks++;
    if (fill_hs - hs0 !== 1) $display("FAIL stall_handshakes: got %0d exp 1", fill_hs - hs0); else n_pass++;
    n_checks++;
    if ({miss_ready_o, req_valid_o, fill_valid_o} !== 3'b100)
      $display("FAIL stall_idle: got %b exp 100", {miss_ready_o, req_valid_o, fill_valid_o});
    else n_pass++;
  endtask

  task automatic test_flush_resp();
    int cyc0;
    cyc0 = fill_cyc;
    start_miss(40'h00_8000_0040);
    accept_req();
    beat(mk(8'hB0, 0), 1'b0);
    beat(mk(8'hB0, 1), 1'b0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_checks++;
    if ({miss_ready_o, req_valid_o, fill_valid_o} !== 3'b000)
      $display("FAIL flushresp_drain: got %b exp 000", {miss_ready_o, req_valid_o, fill_valid_o});
    else n_pass++;
    beat(mk(8'hEE, 2), 1'b0);
    beat(mk(8'hEE, 3), 1'b0);
    n_checks++;
    if (miss_ready_o !== 1'b1) $display("FAIL flushresp_idle: got %b exp 1", miss_ready_o); else n_pass++;
    n_checks++;
    if (fill_cyc - cyc0 !== 0) $display("FAIL flushresp_no_fill: got %0d exp 0", fill_cyc - cyc0); else n_pass++;
    start_miss(40'h00_0000_1040);
    accept_req();
    for (int k = 0; k < 4; k++) beat(mk(8'hC0, k), 1'b0);
    n_checks++;
    if ({fill_valid_o, fill_paddr_o} !== {1'b1, 40'h00_0000_1040})
      $display("FAIL flushresp_new_fill: got %b %h exp 1 0000001040", fill_valid_o, fill_paddr_o);
    else n_pass++;
    n_checks++;
    if (fill_data_o !== mk_line(8'hC0))
      $display("FAIL flushresp_new_data: got %h exp %h", fill_data_o, mk_line(8'hC0));
    else n_pass++;
    take_fill();
  endtask

  task automatic test_flush_req();
    int cyc0;
    cyc0 = fill_cyc;
    start_miss(40'h00_0000_2000);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick(); tick();
    n_checks++;
    if ({req_valid_o, req_paddr_o} !== {1'b1, 40'h00_0000_2000})
      $display("FAIL flushreq_held: got %b %h exp 1 0000002000", req_valid_o, req_paddr_o);
    else n_pass++;
    accept_req();
    n_checks++;
    if ({miss_ready_o, req_valid_o, fill_valid_o} !== 3'b000)
      $display("FAIL flushreq_drain: got %b exp 000", {miss_ready_o, req_valid_o, fill_valid_o});
    else n_pass++;
    for (int k = 0; k < 3; k++) beat(mk(8'hDD, k), 1'b0);
    n_checks++;
    if (miss_ready_o !== 1'b0) $display("FAIL flushreq_still_drain: got %b exp 0", miss_ready_o); else n_pass++;
    beat(mk(8'hDD, 3), 1'b0);
    n_checks++;
    if (miss_ready_o !== 1'b1) $display("FAIL flushreq_idle: got %b exp 1", miss_ready_o); else n_pass++;
    n_checks++;
    if (fill_cyc - cyc0 !== 0) $display("FAIL flushreq_no_fill: got %0d exp 0", fill_cyc - cyc0); else n_pass++;
  endtask

  task automatic test_error();
    start_miss(40'h00_0000_3000);
    accept_req();
    for (int k = 0; k < 4; k++) beat(mk(8'h55, k), (k == 2));
    n_checks++;
    if ({fill_valid_o, fill_error_o} !== 2'b11)
      $display("FAIL error_set: got %b exp 11", {fill_valid_o, fill_error_o});
    else n_pass++;
    take_fill();
    start_miss(40'h00_0000_3040);
    accept_req();
    for (int k = 0; k < 4; k++) beat(mk(8'h66, k), 1'b0);
    n_checks++;
    if ({fill_valid_o, fill_error_o} !== 2'b10)
      $display("FAIL error_clear: got %b exp 10", {fill_valid_o, fill_error_o});
    else n_pass++;
    take_fill();
  endtask

  task automatic test_reset_mid();
    start_miss(40'h00_0000_4000);
    accept_req();
    beat(mk(8'h77, 0), 1'b0);
    beat(mk(8'h77, 1), 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_checks++;
    if ({miss_ready_o, req_valid_o, fill_valid_o, fill_error_o, req_paddr_o, fill_paddr_o} !== {4'b1000, 80'h0})
      $display("FAIL rstmid_outputs: got %b %h %h exp 1000 0 0",
               {miss_ready_o, req_valid_o, fill_valid_o, fill_error_o}, req_paddr_o, fill_paddr_o);
    else n_pass++;
    beat(mk(8'h99, 2), 1'b1);
    n_checks++;
    if ({miss_ready_o, req_valid_o, fill_valid_o, fill_error_o} !== 4'b1000)
      $display("FAIL rstmid_stray: got %b exp 1000", {miss_ready_o, req_valid_o, fill_valid_o, fill_error_o});
    else n_pass++;
    start_miss(40'h00_0000_4080);
    accept_req();
    for (int k = 0; k < 4; k++) beat(mk(8'h88, k), 1'b0);
    n_checks++;
    if ({fill_valid_o, fill_error_o, fill_paddr_o} !== {2'b10, 40'h00_0000_4080})
      $display("FAIL rstmid_fill: got %b%b %h exp 10 0000004080", fill_valid_o, fill_error_o, fill_paddr_o);
    else n_pass++;
    n_checks++;
    if (fill_data_o !== mk_line(8'h88))
      $display("FAIL rstmid_data: got %h exp %h", fill_data_o, mk_line(8'h88));
    else n_pass++;
    take_fill();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_flush_resp();
    test_flush_req();
    test_error();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
